id_stage_elastic: RTL and testbench
===================================

Name: id_stage_elastic

Overview:
Parametrised successor to the single-register decode stage. It decodes RV32I instructions from IF and flags illegal encodings. It captures register-file operands and holds decoded entries in a DEPTH-entry elastic buffer with a valid/ready handshake on both sides. Buffered operands are kept current by snooping writeback, and a flush input supports redirects. It sits between IF and EX.

Parameters:
XLEN, 32, data width of operands and writeback value
DEPTH, 2, number of decoded-entry buffer slots (>=1; need not be a power of two)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  stage enable; low forces in_rdy=0 but the buffer still drains
flush  in  1  synchronous pipeline flush
in_valid  in  1  IF entry valid
in_rdy  out  1  stage accepts IF entry this cycle
if_id  in  core::if_id_t  pc and inst from IF
rf_read_req  out  core::rf_read_req_t  rs1_num/rs2_num of the incoming inst (combinational)
rf_read_rsp  in  core::rf_read_rsp_t  rs1_value/rs2_value, same cycle
wb_valid  in  1  writeback occurring this cycle
wb_rd_num  in  5  writeback destination
wb_value  in  XLEN  writeback data
out_valid  out  1  head entry valid
out_rdy  in  1  EX accepts head entry
id_ex  out  core::id_ex_t  head entry: pc, inst, de_inst (incl. illegal), rs1_value, rs2_value, valid
occupancy  out  $clog2(DEPTH+1)  entries held

Behaviour:
- Reset, asynchronous: count=0, rd/wr pointers=0, out_valid=0, id_ex=core::id_ex_rst, occupancy=0. Deassertion is sampled synchronously.
- in_rdy = en && !flush && (count<DEPTH || out_rdy). Push = in_valid && in_rdy. Pop = out_valid && out_rdy.
- out_valid = (count!=0). id_ex always shows the head slot. When count==0, id_ex=id_ex_rst.
- Latency: a push into an empty buffer gives out_valid=1 on the next cycle. There is no combinational in->out path.
- Push and pop in the same cycle are legal at any count, including full. Count is unchanged and the pointers advance.
- Pointers wrap by compare (ptr==DEPTH-1 -> 0).
- Decode matches the existing stage: opcode, funct3, funct7, rs1/rs2/rd numbers, imm by format, and has_rs1/rs2/rd per opcode.
- illegal=1 in any of these cases:
  - opcode is not one of lui/auipc/jal/jalr/branch/load/store/op/imm_op;
  - jalr with funct3!=0;
  - branch with funct3 in {2,3};
  - load with funct3 in {3,6,7};
  - store with funct3>2;
  - op with funct7 not in {0x00,0x20}, or funct7=0x20 with funct3 not in {0,5};
  - imm_op with funct3=1 and funct7!=0;
  - imm_op with funct3=5 and funct7 not in {0x00,0x20}.
- When illegal=1: has_rs1/rs2/rd=0 and imm=0. The entry is still pushed with valid=1 so EX raises the trap.
- Operand capture at push: rsN_value = (wb_valid && wb_rd_num==rsN_num && rsN_num!=0 && has_rsN) ? wb_value : rf_read_rsp.rsN_value.
- Snoop: each cycle, every stored entry with has_rsN and rsN_num==wb_rd_num!=0 takes wb_value when wb_valid=1. The update is visible the next cycle.
- An entry popped in the same cycle as a matching writeback leaves with the old value. EX forwarding covers this case.
- x0 is never updated by snoop or capture bypass.
- Flush has priority over push, pop and snoop. Count and pointers go to 0, and out_valid=0 on the next cycle. The IF entry presented in the flush cycle is dropped (in_rdy=0).
- Flush while empty is a no-op.
- rst asserted mid-operation discards all entries immediately.
- if_id.valid=0 with in_valid=1 pushes an entry with valid=0 (bubble). The entry occupies a slot and pops normally.

Decomposition:
- core package: add an illegal bit to de_inst_t and to id_ex_rst.
- rv32i package: opcode constants already exist; add funct3/funct7 legality constants.
- One sub-module, id_decoder: combinational, if_id.inst -> core::de_inst_t, including illegal. It is reused by any future multi-issue decode.
- Buffer storage, pointers, snoop and flush stay in id_stage_elastic.

Test Plan:
- Reset then push addi x5,x0,7 (0x00700293) with out_rdy=1 -> next cycle out_valid=1, imm=7, has_rd=1, has_rs1=1, illegal=0; occupancy returns to 0 after pop.
- DEPTH=2, out_rdy=0, push 3 instructions back-to-back -> in_rdy=0 on the 3rd cycle, occupancy=2; raise out_rdy -> entries pop in order with correct pcs, and push/pop at full holds occupancy=2.
- Buffer add x3,x1,x2 with out_rdy=0 and rf rs1=10; then wb_valid=1, wb_rd_num=1, wb_value=99 -> head rs1_value=99 next cycle; same test with wb_rd_num=0 -> value unchanged.
- Push with same-cycle wb_valid, rd=rs2 of the incoming inst -> captured rs2_value=wb_value, not the rf value.
- Inst 0x0000707F (opcode 0x7F), and sub with funct3=1 (funct7=0x20) -> both pop with illegal=1 and has_rd=0.
- Fill 2 entries, assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, the flush-cycle inst is never output; assert rst asynchronously mid-fill -> out_valid drops without waiting for a clock edge.

Source files
------------

// File: rtl/id_stage_elastic_pkg.sv
// RV32I encodings and the core pipeline types shared by the decode stage.
// rv32i holds instruction encodings; core holds the inter-stage structs.
package rv32i;
    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_IMM_OP = 7'b0010011
    } opcode_e;

    localparam logic [2:0] F3_JALR      = 3'd0;
    localparam logic [2:0] F3_ADD_SUB   = 3'd0;
    localparam logic [2:0] F3_SLL       = 3'd1;
    localparam logic [2:0] F3_SRL_SRA   = 3'd5;
    localparam logic [2:0] F3_STORE_MAX = 3'd2;
    localparam logic [6:0] F7_BASE      = 7'h00;
    localparam logic [6:0] F7_ALT       = 7'h20;
endpackage

package core;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    typedef struct packed {
        logic [4:0] rs1_num;
        logic [4:0] rs2_num;
    } rf_read_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
    } rf_read_rsp_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_num;
        logic [4:0]  rs2_num;
        logic [4:0]  rd_num;
        logic [31:0] imm;
        logic        has_rs1;
        logic        has_rs2;
        logic        has_rd;
        logic        illegal;
    } de_inst_t;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     inst;
        de_inst_t        de_inst;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
        logic            valid;
    } id_ex_t;

    localparam id_ex_t id_ex_rst = '0;
endpackage

// File: rtl/id_stage_elastic_decoder.sv
// Combinational RV32I decoder: instruction word to de_inst_t with legality check.
module id_decoder
    import rv32i::*;
(
    input  logic [31:0]    inst,
    output core::de_inst_t de_inst
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        use_rs1, use_rs2, use_rd, illegal;
    logic [31:0] imm;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        imm     = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                use_rd = 1'b1;
                imm    = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                imm    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = {{20{inst[31]}}, inst[31:20]};
                illegal = (funct3 != F3_JALR);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                illegal = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = {{20{inst[31]}}, inst[31:20]};
                illegal = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                illegal = (funct3 > F3_STORE_MAX);
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                illegal = !((funct7 == F7_BASE) ||
                            (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
            end
            OPC_IMM_OP: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = {{20{inst[31]}}, inst[31:20]};
                illegal = ((funct3 == F3_SLL) && (funct7 != F7_BASE)) ||
                          ((funct3 == F3_SRL_SRA) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
            end
            default: illegal = 1'b1;
        endcase
        // Illegal entries carry no operand/destination usage so EX sees a clean trap.
        if (illegal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
            use_rd  = 1'b0;
            imm     = '0;
        end
    end

    always_comb begin
        de_inst         = '0;
        de_inst.opcode  = opcode;
        de_inst.funct3  = funct3;
        de_inst.funct7  = funct7;
        de_inst.rs1_num = inst[19:15];
        de_inst.rs2_num = inst[24:20];
        de_inst.rd_num  = inst[11:7];
        de_inst.imm     = imm;
        de_inst.has_rs1 = use_rs1;
        de_inst.has_rs2 = use_rs2;
        de_inst.has_rd  = use_rd;
        de_inst.illegal = illegal;
    end
endmodule

// File: rtl/id_stage_elastic.sv
// Elastic decode stage: decodes IF entries into a DEPTH-slot FIFO whose
// buffered operands track writeback until they leave for EX.
module id_stage_elastic #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_rdy,
    input  core::if_id_t               if_id,
    output core::rf_read_req_t         rf_read_req,
    input  core::rf_read_rsp_t         rf_read_rsp,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd_num,
    input  logic [XLEN-1:0]            wb_value,
    output logic                       out_valid,
    input  logic                       out_rdy,
    output core::id_ex_t               id_ex,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    core::id_ex_t   slot [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    core::de_inst_t dec;
    core::id_ex_t   entry_in;
    logic           push, pop, wb_hit;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    id_decoder u_dec (
        .inst   (if_id.inst),
        .de_inst(dec)
    );

    assign rf_read_req.rs1_num = if_id.inst[19:15];
    assign rf_read_req.rs2_num = if_id.inst[24:20];

    assign out_valid = (count != '0);
    assign in_rdy    = en && !flush && ((count < CW'(DEPTH)) || out_rdy);
    assign push      = in_valid && in_rdy;
    assign pop       = out_valid && out_rdy;
    assign id_ex     = out_valid ? slot[rd_ptr] : core::id_ex_rst;
    assign occupancy = count;
    assign wb_hit    = wb_valid && (wb_rd_num != 5'd0);

    always_comb begin
        entry_in           = core::id_ex_rst;
        entry_in.pc        = if_id.pc;
        entry_in.inst      = if_id.inst;
        entry_in.de_inst   = dec;
        entry_in.valid     = if_id.valid;
        entry_in.rs1_value = (wb_hit && dec.has_rs1 && wb_rd_num == dec.rs1_num)
                             ? wb_value : rf_read_rsp.rs1_value;
        entry_in.rs2_value = (wb_hit && dec.has_rs2 && wb_rd_num == dec.rs2_num)
                             ? wb_value : rf_read_rsp.rs2_value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) slot[i] <= core::id_ex_rst;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // Snoop every slot; a push into the same slot below takes precedence.
            if (wb_hit) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (slot[i].de_inst.has_rs1 && slot[i].de_inst.rs1_num == wb_rd_num)
                        slot[i].rs1_value <= wb_value;
                    if (slot[i].de_inst.has_rs2 && slot[i].de_inst.rs2_num == wb_rd_num)
                        slot[i].rs2_value <= wb_value;
                end
            end
            if (push) begin
                slot[wr_ptr] <= entry_in;
                wr_ptr       <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_id_stage_elastic.sv
// Directed and randomized checks of id_stage_elastic against a queue-based model.
module tb_id_stage_elastic;
    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst, en, flush, in_valid, out_rdy, wb_valid;
    logic               in_rdy, out_valid;
    core::if_id_t       if_id;
    core::rf_read_req_t rf_read_req;
    core::rf_read_rsp_t rf_read_rsp;
    logic [4:0]         wb_rd_num;
    logic [31:0]        wb_value;
    core::id_ex_t       id_ex;
    logic [1:0]         occupancy;

    int errors = 0;
    int checks = 0;
    core::id_ex_t q[$];

    id_stage_elastic #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_rdy(in_rdy), .if_id(if_id),
        .rf_read_req(rf_read_req), .rf_read_rsp(rf_read_rsp),
        .wb_valid(wb_valid), .wb_rd_num(wb_rd_num), .wb_value(wb_value),
        .out_valid(out_valid), .out_rdy(out_rdy), .id_ex(id_ex),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the legality table and immediate formats.
    function automatic core::de_inst_t ref_decode(input logic [31:0] w);
        core::de_inst_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic bad;
        f3 = w[14:12];
        f7 = w[31:25];
        d = '0;
        d.opcode = w[6:0]; d.funct3 = f3; d.funct7 = f7;
        d.rs1_num = w[19:15]; d.rs2_num = w[24:20]; d.rd_num = w[11:7];
        bad = 1'b0;
        case (w[6:0])
            7'h37, 7'h17: begin d.has_rd = 1; d.imm = {w[31:12], 12'h000}; end
            7'h6F: begin d.has_rd = 1; d.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
            7'h67: begin d.has_rs1 = 1; d.has_rd = 1; d.imm = {{20{w[31]}}, w[31:20]}; bad = (f3 != 0); end
            7'h63: begin d.has_rs1 = 1; d.has_rs2 = 1;
                         d.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
                         bad = (f3 == 2 || f3 == 3); end
            7'h03: begin d.has_rs1 = 1; d.has_rd = 1; d.imm = {{20{w[31]}}, w[31:20]};
                         bad = (f3 == 3 || f3 == 6 || f3 == 7); end
            7'h23: begin d.has_rs1 = 1; d.has_rs2 = 1; d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                         bad = (f3 > 2); end
            7'h33: begin d.has_rs1 = 1; d.has_rs2 = 1; d.has_rd = 1;
                         bad = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && !(f3 == 0 || f3 == 5)); end
            7'h13: begin d.has_rs1 = 1; d.has_rd = 1; d.imm = {{20{w[31]}}, w[31:20]};
                         bad = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 7'h00 || f7 == 7'h20)); end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            d.has_rs1 = 0; d.has_rs2 = 0; d.has_rd = 0; d.imm = '0;
        end
        d.illegal = bad;
        return d;
    endfunction

    // Checks current outputs against the model, then advances one clock and the model.
    task automatic cycle();
        logic exp_rdy;
        core::id_ex_t e;
        #1;
        exp_rdy = en && !flush && (q.size() < DEPTH || out_rdy);
        chk("out_valid", out_valid, q.size() != 0);
        chk("occupancy", occupancy, q.size());
        chk("id_ex", id_ex, (q.size() != 0) ? q[0] : core::id_ex_t'('0));
        chk("in_rdy", in_rdy, exp_rdy);
        chk("rf_read_req", rf_read_req, {if_id.inst[19:15], if_id.inst[24:20]});
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_rdy) void'(q.pop_front());
            if (wb_valid && wb_rd_num != 0) begin
                foreach (q[i]) begin
                    if (q[i].de_inst.has_rs1 && q[i].de_inst.rs1_num == wb_rd_num) q[i].rs1_value = wb_value;
                    if (q[i].de_inst.has_rs2 && q[i].de_inst.rs2_num == wb_rd_num) q[i].rs2_value = wb_value;
                end
            end
            if (in_valid && exp_rdy) begin
                e = '0;
                e.pc = if_id.pc; e.inst = if_id.inst; e.valid = if_id.valid;
                e.de_inst = ref_decode(if_id.inst);
                e.rs1_value = rf_read_rsp.rs1_value;
                e.rs2_value = rf_read_rsp.rs2_value;
                if (wb_valid && wb_rd_num != 0) begin
                    if (e.de_inst.has_rs1 && e.de_inst.rs1_num == wb_rd_num) e.rs1_value = wb_value;
                    if (e.de_inst.has_rs2 && e.de_inst.rs2_num == wb_rd_num) e.rs2_value = wb_value;
                end
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        if_id.pc = pc;
        if_id.inst = inst;
        if_id.valid = 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0] ops [0:9];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h33, 7'h13, 7'h7F};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; out_rdy = 1'b0;
        wb_valid = 1'b0; wb_rd_num = '0; wb_value = '0;
        rf_read_rsp = '0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_occupancy", occupancy, 2'd0);
        chk("reset_id_ex", id_ex, core::id_ex_rst);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // addi x5,x0,7 through an empty buffer
        out_rdy = 1'b1;
        rf_read_rsp = '{rs1_value: 32'h0, rs2_value: 32'h7};
        drive(1'b1, 32'h100, 32'h00700293);
        cycle();
        drive(1'b0, 32'h104, 32'h0);
        #1;
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_imm", id_ex.de_inst.imm, 32'd7);
        chk("addi_has_rd", id_ex.de_inst.has_rd, 1'b1);
        chk("addi_has_rs1", id_ex.de_inst.has_rs1, 1'b1);
        chk("addi_illegal", id_ex.de_inst.illegal, 1'b0);
        cycle();
        chk("addi_drained", occupancy, 2'd0);

        // Fill to DEPTH with EX stalled, then push/pop at full
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'h00100093 + 32'(i << 20));
            cycle();
        end
        #1;
        chk("full_in_rdy_low", in_rdy, 1'b0);
        chk("full_occupancy", occupancy, 2'd2);
        chk("full_head_pc", id_ex.pc, 32'h200);
        out_rdy = 1'b1;
        drive(1'b1, 32'h20C, 32'h00400093);
        cycle();
        chk("pushpop_occupancy", occupancy, 2'd2);
        chk("pushpop_head_pc", id_ex.pc, 32'h204);
        drive(1'b0, 32'h0, 32'h0);
        cycle(); cycle();

        // Snoop into buffered add x3,x1,x2 and an x0-sourced addi
        out_rdy = 1'b0;
        rf_read_rsp = '{rs1_value: 32'd10, rs2_value: 32'd20};
        drive(1'b1, 32'h300, 32'h002081B3);
        cycle();
        rf_read_rsp = '{rs1_value: 32'd0, rs2_value: 32'd5};
        drive(1'b1, 32'h304, 32'h00700293);
        cycle();
        drive(1'b0, 32'h0, 32'h0);
        wb_valid = 1'b1; wb_rd_num = 5'd1; wb_value = 32'd99;
        cycle();
        chk("snoop_rs1", id_ex.rs1_value, 32'd99);
        wb_rd_num = 5'd0; wb_value = 32'd77;
        cycle();
        chk("snoop_x0_head", id_ex.rs1_value, 32'd99);
        wb_valid = 1'b0;
        out_rdy = 1'b1;
        cycle();
        chk("snoop_x0_second", id_ex.rs1_value, 32'd0);
        cycle();

        // Capture bypass on rs2
        out_rdy = 1'b0;
        rf_read_rsp = '{rs1_value: 32'hA, rs2_value: 32'h1234};
        wb_valid = 1'b1; wb_rd_num = 5'd2; wb_value = 32'h55;
        drive(1'b1, 32'h400, 32'h002081B3);
        cycle();
        wb_valid = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("bypass_rs2", id_ex.rs2_value, 32'h55);
        chk("bypass_rs1_rf", id_ex.rs1_value, 32'hA);
        out_rdy = 1'b1;
        cycle();

        // Illegal encodings
        drive(1'b1, 32'h500, 32'h0000707F);
        cycle();
        chk("ill_opc", id_ex.de_inst.illegal, 1'b1);
        chk("ill_opc_rd", id_ex.de_inst.has_rd, 1'b0);
        drive(1'b1, 32'h504, 32'h402091B3);
        cycle();
        chk("ill_sub_f3", id_ex.de_inst.illegal, 1'b1);
        chk("ill_sub_rd", id_ex.de_inst.has_rd, 1'b0);
        chk("ill_entry_valid", id_ex.valid, 1'b1);
        drive(1'b0, 32'h0, 32'h0);
        cycle();

        // Flush with a pending IF entry
        out_rdy = 1'b0;
        drive(1'b1, 32'h600, 32'h00100093); cycle();
        drive(1'b1, 32'h604, 32'h00200093); cycle();
        flush = 1'b1;
        drive(1'b1, 32'h608, 32'h00300093);
        cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_occupancy", occupancy, 2'd0);
        out_rdy = 1'b1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            en       = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            out_rdy  = ($urandom_range(0, 2) != 0);
            wb_valid = ($urandom_range(0, 1) == 1);
            wb_rd_num = 5'($urandom_range(0, 3));
            wb_value = $urandom;
            rf_read_rsp = '{rs1_value: $urandom, rs2_value: $urandom};
            drive(($urandom_range(0, 3) != 0), $urandom, rand_inst());
            if_id.valid = ($urandom_range(0, 7) != 0);
            cycle();
        end

        // Asynchronous reset mid-fill
        en = 1'b1; flush = 1'b0; out_rdy = 1'b0; wb_valid = 1'b0;
        drive(1'b1, 32'h700, 32'h00100093);
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_occupancy", occupancy, 2'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
